time_set_ctrl: RTL and testbench
================================

// Module: time_set_ctrl
// PURPOSE
//  Button-driven time-setting controller for the digital clock.
//  - Sequences user entry of hours, then minutes, from two raw push-buttons.
//  - Builds a 20-bit BCD time word and issues a one-cycle load pulse to the
//    clockWorkDec time-overwrite input.
//  - Sits between the raw button pins and the clock datapath.
//  - Replaces per-digit button counters with one FSM.
// PARAMETERS
//  DB_CYCLES      1000  clk cycles an input must stay stable to be accepted (>=2)
//  TIMEOUT_TICKS  30    tick_1hz pulses with no press before a SET mode aborts (>=1)
// PORTS
//  clk          in   1   system clock; all state on rising edge
//  time_ow      in   1   reset; asynchronous, active-high
//  tick_1hz     in   1   one-clk-wide pulse, once per second (from clock_1sec)
//  btn_mode     in   1   raw mode button, asynchronous, active-high
//  btn_inc      in   1   raw increment button, asynchronous, active-high
//  time_cur     in   20  running time {hh_hhhh, mmm_mmmm, sss_ssss}, BCD
//  time_load    out  20  time word to overwrite the clock; valid when load_pulse=1
//  load_pulse   out  1   one-cycle strobe: write time_load into the clock
//  set_active   out  1   1 while in SET_HRS or SET_MIN
//  blink_hrs    out  1   display blanking for the hours field
//  blink_min    out  1   display blanking for the minutes field
//  mode_state   out  2   FSM state code, for debug and display
// BEHAVIOUR
//  Reset (time_ow=1, async):
//   - state=RUN; shadow hours/minutes=00:00; blink phase=0; timeout count=0.
//   - Debouncers clear to level 0.
//   - All outputs 0.
//  Input conditioning:
//   - Each button passes a 2-flop synchroniser, then a debouncer.
//   - The debounced level changes only after the synchronised input has
//     differed from it for DB_CYCLES consecutive clk.
//   - A 0->1 debounced edge yields one press pulse.
//   - Latency from a clean raw edge to the press pulse: DB_CYCLES+3 clk.
//  FSM states:
//   RUN=00
//    - mode press: capture time_cur hours and minutes into shadow; go SET_HRS.
//    - If captured hours >23 or minutes >59, that field loads as 00.
//   SET_HRS=01
//    - inc press: hours +1, BCD (units 9->0 with tens+1); 23->00.
//    - mode press: go SET_MIN.
//   SET_MIN=10
//    - inc press: minutes +1, BCD; 59->00. No carry into hours.
//    - mode press: go COMMIT.
//   COMMIT=11
//    - Lasts one clk: load_pulse=1; time_load={shadow hh, shadow mm, sss_ssss=0}.
//    - Next state RUN.
//  Simultaneous events:
//   - mode and inc press in the same clk: mode wins; inc is dropped.
//   - Presses during COMMIT are ignored.
//  Timeout:
//   - Counter clears on entry to SET_HRS and on every press.
//   - Counter increments on tick_1hz while set_active=1.
//   - When it reaches TIMEOUT_TICKS: go RUN, no load_pulse, shadow retained.
//  Blink:
//   - Phase toggles on each tick_1hz while set_active; phase clears in RUN.
//   - blink_hrs = (state==SET_HRS) & phase.
//   - blink_min = (state==SET_MIN) & phase.
//  Output timing:
//   - time_load is registered and held between loads.
//   - time_load updates only when COMMIT is entered.
//   - load_pulse is never high for 2 consecutive clk.
//   - set_active and mode_state are registered, with no combinational path
//     from any input.
//  Reset mid-operation: abandons the edit; no load_pulse is emitted.
// STRUCTURE
//  Package clock_pkg:
//   - TIME_W=20; field widths HT_W=2, HU_W=4, MT_W=3, MU_W=4, ST_W=3, SU_W=4.
//   - State enum {RUN, SET_HRS, SET_MIN, COMMIT}.
//   - BCD limits HRS_MAX=8'h23, MIN_MAX=8'h59.
//   - Pack/unpack functions for the 20-bit time word.
//  Sub-module btn_debounce (synchroniser + debouncer + edge detect, DB_CYCLES
//  parameter), instantiated once per button. FSM and BCD incrementers stay in
//  this module.
// TESTING
//  T1 Reset: assert time_ow mid-SET_MIN -> state RUN and all outputs 0 in the
//     same cycle; no load_pulse after release.
//  T2 Full set: time_cur=13:45:27; mode, inc x3, mode, inc x2, mode ->
//     exactly one load_pulse, time_load=16:47:00.
//  T3 Wrap: capture 23:59; inc in SET_HRS -> 00; inc in SET_MIN -> 00, hours
//     unchanged; commit -> time_load=00:00:00.
//  T4 Debounce: glitches shorter than DB_CYCLES-1 produce no press; clean
//     press -> press pulse exactly DB_CYCLES+3 clk after the raw edge.
//  T5 Timeout (TIMEOUT_TICKS=3): enter SET_HRS, 3 ticks with no press -> RUN,
//     no load_pulse; blink_hrs toggles on ticks 1 and 2.
//  T6 Collision and sanitising: mode and inc presses on the same clk in SET_HRS
//     -> SET_MIN, hours unchanged; capture hours BCD 8'h27 -> shadow hours 00.

Source files
------------

// File: rtl/time_set_ctrl_pkg.sv
// Shared time-word layout, FSM state codes and BCD limits for the time-setting controller.
package clock_pkg;

  localparam int TIME_W = 20;
  localparam int HT_W   = 2;
  localparam int HU_W   = 4;
  localparam int MT_W   = 3;
  localparam int MU_W   = 4;
  localparam int ST_W   = 3;
  localparam int SU_W   = 4;

  localparam int S_LSB = 0;
  localparam int M_LSB = S_LSB + ST_W + SU_W;
  localparam int H_LSB = M_LSB + MT_W + MU_W;

  localparam logic [7:0] HRS_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX = 8'h59;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HRS = 2'b01,
    SET_MIN = 2'b10,
    COMMIT  = 2'b11
  } state_e;

  function automatic logic [TIME_W-1:0] pack_time(input logic [7:0] hh,
                                                  input logic [7:0] mm,
                                                  input logic [7:0] ss);
    return {hh[HT_W+HU_W-1:0], mm[MT_W+MU_W-1:0], ss[ST_W+SU_W-1:0]};
  endfunction

  function automatic logic [7:0] unpack_hrs(input logic [TIME_W-1:0] t);
    return {2'b00, t[H_LSB +: HT_W+HU_W]};
  endfunction

  function automatic logic [7:0] unpack_min(input logic [TIME_W-1:0] t);
    return {1'b0, t[M_LSB +: MT_W+MU_W]};
  endfunction

  function automatic logic [7:0] unpack_sec(input logic [TIME_W-1:0] t);
    return {1'b0, t[S_LSB +: ST_W+SU_W]};
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Button, tick and time-word bundle between the clock datapath and the time-setting controller.
interface time_set_ctrl_if;
  import clock_pkg::*;

  logic              tick_1hz;
  logic              btn_mode;
  logic              btn_inc;
  logic [TIME_W-1:0] time_cur;
  logic [TIME_W-1:0] time_load;
  logic              load_pulse;
  logic              set_active;
  logic              blink_hrs;
  logic              blink_min;
  logic [1:0]        mode_state;

  modport master (
    output tick_1hz, btn_mode, btn_inc, time_cur,
    input  time_load, load_pulse, set_active, blink_hrs, blink_min, mode_state
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_inc, time_cur,
    output time_load, load_pulse, set_active, blink_hrs, blink_min, mode_state
  );

endinterface

// File: rtl/time_set_ctrl_debounce.sv
// Raw push-button conditioning: 2-flop synchroniser, stability debouncer, rising-edge press pulse.
module btn_debounce #(
  parameter int DB_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int               CNT_W    = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_q;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // Down-counter restarts whenever the input agrees with the accepted level,
  // so the level only flips after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= CNT_LOAD;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_q <= r_level;
      r_press   <= r_level & ~r_level_q;
      if (r_sync2 == r_level) begin
        r_cnt <= CNT_LOAD;
      end else if (r_cnt == '0) begin
        r_level <= r_sync2;
        r_cnt   <= CNT_LOAD;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven hours/minutes entry FSM; emits a one-cycle load strobe with the new BCD time word.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int DB_CYCLES     = 1000,
  parameter int TIMEOUT_TICKS = 30
) (
  input  logic           clk,
  input  logic           time_ow,
  time_set_ctrl_if.slave bus
);

  localparam int            TO_W    = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_TICKS);

  function automatic logic [7:0] bcd_sanitize(input logic [7:0] v, input logic [7:0] vmax);
    return ((v > vmax) || (v[3:0] > 4'd9)) ? 8'h00 : v;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
    if (v >= vmax) return 8'h00;
    if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'h0};
    return v + 8'd1;
  endfunction

  logic w_press_mode;
  logic w_press_inc;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk     (clk),
    .rst     (time_ow),
    .i_btn   (bus.btn_mode),
    .o_press (w_press_mode)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
    .clk     (clk),
    .rst     (time_ow),
    .i_btn   (bus.btn_inc),
    .o_press (w_press_inc)
  );

  state_e            r_state,     w_next_state;
  logic [7:0]        r_hrs,       w_next_hrs;
  logic [7:0]        r_min,       w_next_min;
  logic              r_phase,     w_next_phase;
  logic [TO_W-1:0]   r_to_cnt,    w_next_to_cnt;
  logic [TIME_W-1:0] r_time_load, w_next_time_load;

  always_ff @(posedge clk or posedge time_ow) begin
    if (time_ow) begin
      r_state     <= RUN;
      r_hrs       <= 8'h00;
      r_min       <= 8'h00;
      r_phase     <= 1'b0;
      r_to_cnt    <= '0;
      r_time_load <= '0;
    end else begin
      r_state     <= w_next_state;
      r_hrs       <= w_next_hrs;
      r_min       <= w_next_min;
      r_phase     <= w_next_phase;
      r_to_cnt    <= w_next_to_cnt;
      r_time_load <= w_next_time_load;
    end
  end

  // Mode press outranks inc press, and any press outranks a timeout tick.
  always_comb begin
    w_next_state     = r_state;
    w_next_hrs       = r_hrs;
    w_next_min       = r_min;
    w_next_phase     = r_phase;
    w_next_to_cnt    = r_to_cnt;
    w_next_time_load = r_time_load;
    case (r_state)
      RUN: begin
        w_next_phase = 1'b0;
        if (w_press_mode) begin
          w_next_hrs    = bcd_sanitize(unpack_hrs(bus.time_cur), HRS_MAX);
          w_next_min    = bcd_sanitize(unpack_min(bus.time_cur), MIN_MAX);
          w_next_to_cnt = TO_LOAD;
          w_next_state  = SET_HRS;
        end
      end
      SET_HRS, SET_MIN: begin
        if (bus.tick_1hz) w_next_phase = ~r_phase;
        if (w_press_mode) begin
          w_next_to_cnt = TO_LOAD;
          if (r_state == SET_HRS) begin
            w_next_state = SET_MIN;
          end else begin
            w_next_state     = COMMIT;
            w_next_time_load = pack_time(r_hrs, r_min, 8'h00);
          end
        end else if (w_press_inc) begin
          w_next_to_cnt = TO_LOAD;
          if (r_state == SET_HRS) w_next_hrs = bcd_inc(r_hrs, HRS_MAX);
          else                    w_next_min = bcd_inc(r_min, MIN_MAX);
        end else if (bus.tick_1hz) begin
          if (r_to_cnt <= TO_W'(1)) w_next_state  = RUN;
          else                      w_next_to_cnt = r_to_cnt - 1'b1;
        end
      end
      COMMIT:  w_next_state = RUN;
      default: w_next_state = RUN;
    endcase
  end

  assign bus.mode_state = r_state;
  assign bus.set_active = (r_state == SET_HRS) || (r_state == SET_MIN);
  assign bus.load_pulse = (r_state == COMMIT);
  assign bus.blink_hrs  = (r_state == SET_HRS) && r_phase;
  assign bus.blink_min  = (r_state == SET_MIN) && r_phase;
  assign bus.time_load  = r_time_load;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench: directed scenarios plus random button/tick traffic against a behavioural model.
module tb_time_set_ctrl;

  localparam int DB = 8;
  localparam int TO = 3;

  logic clk     = 1'b0;
  logic time_ow = 1'b1;

  time_set_ctrl_if bus ();

  time_set_ctrl #(.DB_CYCLES(DB), .TIMEOUT_TICKS(TO)) dut (
    .clk     (clk),
    .time_ow (time_ow),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_tests   = 0;
  int n_fail    = 0;
  int dut_loads = 0;
  bit auto_tick = 1'b0;
  bit tick_req  = 1'b0;

  // model: raw sample history per button, accepted level, press pipeline, edit state
  bit          rh[2][DB+2];
  bit          lvl[2];
  bit          rose[2][2];
  int          m_state;
  int          m_hrs;
  int          m_min;
  bit          m_phase;
  int          m_elapsed;
  logic [19:0] m_load;

  function automatic logic [19:0] word(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int j = 0; j < DB + 2; j++) rh[b][j] = 1'b0;
      lvl[b]     = 1'b0;
      rose[b][0] = 1'b0;
      rose[b][1] = 1'b0;
    end
    m_state = 0; m_hrs = 0; m_min = 0; m_phase = 1'b0; m_elapsed = 0; m_load = '0;
  endtask

  task automatic model_step();
    bit          raw[2];
    bit          pr[2];
    bit          all_diff;
    bit          tk;
    logic [19:0] cur;
    raw[0] = bus.btn_mode;
    raw[1] = bus.btn_inc;
    tk     = bus.tick_1hz;
    cur    = bus.time_cur;
    for (int b = 0; b < 2; b++) begin
      pr[b]      = rose[b][1];
      rose[b][1] = rose[b][0];
      for (int j = DB + 1; j > 0; j--) rh[b][j] = rh[b][j-1];
      rh[b][0] = raw[b];
      all_diff = 1'b1;
      for (int j = 2; j < DB + 2; j++) if (rh[b][j] == lvl[b]) all_diff = 1'b0;
      rose[b][0] = 1'b0;
      if (all_diff) begin
        lvl[b]     = ~lvl[b];
        rose[b][0] = lvl[b];
      end
    end
    case (m_state)
      0: begin
        m_phase = 1'b0;
        if (pr[0]) begin
          m_hrs = int'(cur[19:18]) * 10 + int'(cur[17:14]);
          m_min = int'(cur[13:11]) * 10 + int'(cur[10:7]);
          if (m_hrs > 23) m_hrs = 0;
          if (m_min > 59) m_min = 0;
          m_elapsed = 0;
          m_state   = 1;
        end
      end
      1, 2: begin
        if (tk) m_phase = ~m_phase;
        if (pr[0]) begin
          m_elapsed = 0;
          if (m_state == 1) m_state = 2;
          else begin
            m_state = 3;
            m_load  = word(m_hrs, m_min, 0);
          end
        end else if (pr[1]) begin
          m_elapsed = 0;
          if (m_state == 1) m_hrs = (m_hrs + 1) % 24;
          else              m_min = (m_min + 1) % 60;
        end else if (tk) begin
          m_elapsed++;
          if (m_elapsed >= TO) m_state = 0;
        end
      end
      default: m_state = 0;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (time_ow) model_reset();
      else         model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!time_ow) begin
        check("mode_state", bus.mode_state, m_state);
        check("set_active", bus.set_active, (m_state == 1 || m_state == 2));
        check("load_pulse", bus.load_pulse, (m_state == 3));
        check("blink_hrs",  bus.blink_hrs,  (m_state == 1 && m_phase));
        check("blink_min",  bus.blink_min,  (m_state == 2 && m_phase));
        check("time_load",  bus.time_load,  m_load);
        if (bus.load_pulse === 1'b1) dut_loads++;
      end
    end
  end

  initial begin
    bus.tick_1hz = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_req) begin
        bus.tick_1hz = 1'b1;
        tick_req     = 1'b0;
      end else if (auto_tick && $urandom_range(0, 19) == 0) bus.tick_1hz = 1'b1;
      else bus.tick_1hz = 1'b0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input bit m, input bit i, input int hold, input int gap);
    @(posedge clk);
    #1;
    if (m) bus.btn_mode = 1'b1;
    if (i) bus.btn_inc  = 1'b1;
    wait_cyc(hold);
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    wait_cyc(gap);
  endtask

  task automatic send_tick();
    @(posedge clk);
    #2;
    tick_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int l0;
    int k;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.time_cur = '0;
    repeat (3) @(posedge clk);
    #1 time_ow = 1'b0;
    wait_cyc(2);
    check("rst_mode_state", bus.mode_state, 0);
    check("rst_set_active", bus.set_active, 0);
    check("rst_time_load",  bus.time_load,  0);

    // full set 13:45:27 -> 16:47:00
    bus.time_cur = word(13, 45, 27);
    l0 = dut_loads;
    press(1, 0, DB + 2, DB + 6);
    check("t2_in_set_hrs", bus.mode_state, 1);
    repeat (3) press(0, 1, DB + 2, DB + 6);
    press(1, 0, DB + 2, DB + 6);
    check("t2_in_set_min", bus.mode_state, 2);
    repeat (2) press(0, 1, DB + 2, DB + 6);
    press(1, 0, DB + 2, DB + 6);
    check("t2_one_load",   dut_loads - l0, 1);
    check("t2_time_load",  bus.time_load, 20'h5A380);
    check("t2_model_load", m_load, 20'h5A380);
    check("t2_back_run",   bus.mode_state, 0);

    // wrap 23:59 -> 00:00
    bus.time_cur = word(23, 59, 10);
    l0 = dut_loads;
    press(1, 0, DB + 2, DB + 6);
    press(0, 1, DB + 2, DB + 6);
    press(1, 0, DB + 2, DB + 6);
    press(0, 1, DB + 2, DB + 6);
    press(1, 0, DB + 2, DB + 6);
    check("t3_one_load",  dut_loads - l0, 1);
    check("t3_time_load", bus.time_load, 20'h00000);

    // glitch rejection, then exact press latency
    press(1, 0, DB - 2, DB + 6);
    check("t4_glitch_ignored", bus.mode_state, 0);
    @(posedge clk);
    #1 bus.btn_mode = 1'b1;
    k = 0;
    while (k < 4 * DB && bus.set_active !== 1'b1) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("t4_latency", k, DB + 4);
    bus.btn_mode = 1'b0;
    wait_cyc(DB + 6);

    // timeout after TO ticks, blink follows ticks
    l0 = dut_loads;
    send_tick();
    check("t5_blink_tick1", bus.blink_hrs, 1);
    check("t5_state_tick1", bus.mode_state, 1);
    send_tick();
    check("t5_blink_tick2", bus.blink_hrs, 0);
    send_tick();
    check("t5_timeout_run", bus.mode_state, 0);
    check("t5_inactive",    bus.set_active, 0);
    wait_cyc(5);
    check("t5_no_load", dut_loads - l0, 0);

    // collision and sanitised capture
    bus.time_cur = word(27, 30, 0);
    l0 = dut_loads;
    press(1, 0, DB + 2, DB + 6);
    press(1, 1, DB + 2, DB + 6);
    check("t6_mode_wins", bus.mode_state, 2);
    press(1, 0, DB + 2, DB + 6);
    check("t6_one_load",  dut_loads - l0, 1);
    check("t6_time_load", bus.time_load, 20'h01800);

    // async reset mid SET_MIN
    press(1, 0, DB + 2, DB + 6);
    press(1, 0, DB + 2, DB + 6);
    check("t1_in_set_min", bus.mode_state, 2);
    @(posedge clk);
    #1 bus.btn_mode = 1'b1;
    wait_cyc(DB);
    #2 time_ow = 1'b1;
    #1;
    check("t1_rst_state",     bus.mode_state, 0);
    check("t1_rst_active",    bus.set_active, 0);
    check("t1_rst_pulse",     bus.load_pulse, 0);
    check("t1_rst_time_load", bus.time_load,  0);
    check("t1_rst_blink_min", bus.blink_min,  0);
    bus.btn_mode = 1'b0;
    l0 = dut_loads;
    repeat (3) @(posedge clk);
    #1 time_ow = 1'b0;
    wait_cyc(3 * DB);
    check("t1_no_load", dut_loads - l0, 0);
    check("t1_run",     bus.mode_state, 0);

    // random traffic
    auto_tick = 1'b1;
    for (int it = 0; it < 300; it++) begin
      int act;
      bus.time_cur = {2'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                      3'($urandom_range(0, 7)), 4'($urandom_range(0, 9)),
                      3'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      act = $urandom_range(0, 9);
      if (act <= 3)      press(1, 0, $urandom_range(DB - 1, DB + 4), $urandom_range(2, DB + 10));
      else if (act <= 6) press(0, 1, $urandom_range(DB - 1, DB + 4), $urandom_range(2, DB + 10));
      else if (act == 7) press(1, 1, $urandom_range(DB - 1, DB + 4), $urandom_range(2, DB + 10));
      else if (act == 8) press($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                               $urandom_range(1, DB - 2), $urandom_range(2, DB));
      else               wait_cyc($urandom_range(5, 60));
    end
    auto_tick = 1'b0;
    wait_cyc(4 * DB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
